// File: rtl/regfile_param.sv
// regfile_param: parametrised control/status register file.
//   NREG registers of DW bits, access type per register from REG_TYPE
//   (2 bits per register: 00=RW, 01=RO, 10=W1C, 11=RC).
//   Registered read data with rvalid strobe; out-of-range accesses raise err.
//   Optional feature macro: REGFILE_IRQ_EN adds an irq output and a mask
//   register at address NREG (bit0 = global interrupt enable).
module regfile_param #(
    parameter int              DW       = 8,
    parameter int              AW       = 8,
    parameter int              NREG     = 4,
    parameter logic [2*NREG-1:0] REG_TYPE = 8'b00_01_10_11,
    parameter logic [DW-1:0]   RST_VAL  = 8'hff
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [AW-1:0]        addr,
    input  logic [DW-1:0]        wdata,
    input  logic                 wen,
    input  logic                 ren,
    output logic [DW-1:0]        rdata,
    output logic                 rvalid,
    output logic                 err,
`ifdef REGFILE_IRQ_EN
    output logic                 irq,
`endif
    input  logic [NREG*DW-1:0]   hw_ro,
    input  logic [NREG*DW-1:0]   hw_set,
    output logic [NREG*DW-1:0]   reg_q
);

    localparam logic [1:0] T_RW  = 2'b00;
    localparam logic [1:0] T_RO  = 2'b01;
    localparam logic [1:0] T_W1C = 2'b10;
    localparam logic [1:0] T_RC  = 2'b11;

`ifdef REGFILE_IRQ_EN
    localparam int NADDR = NREG + 1;
`else
    localparam int NADDR = NREG;
`endif

    localparam logic [AW:0] NADDR_V = (AW+1)'(NADDR);

    logic          in_range;
    logic [DW-1:0] rd_mux;

    // Only slices belonging to RO (hw_ro) or W1C/RC (hw_set) registers are
    // consumed; the reduction marks the remaining bits as intentionally idle.
    logic unused_hw_bits;
    assign unused_hw_bits = ^{hw_ro, hw_set};

    assign in_range = ({1'b0, addr} < NADDR_V);

    for (genvar i = 0; i < NREG; i++) begin : g_reg
        localparam logic [1:0] TYPE = REG_TYPE[2*i +: 2];

        logic          wen_hit;
        logic          ren_hit;
        logic [DW-1:0] q;

        assign wen_hit = wen && (addr == AW'(i));
        assign ren_hit = ren && (addr == AW'(i));
        assign reg_q[DW*i +: DW] = q;

        if (TYPE == T_RW) begin : g_rw
            // Plain read/write storage.
            always_ff @(posedge clk) begin
                if (rst)
                    q <= RST_VAL;
                else if (wen_hit)
                    q <= wdata;
            end
        end else if (TYPE == T_RO) begin : g_ro
            // Status mirror: samples the hardware value every cycle, host
            // writes have no effect.
            always_ff @(posedge clk) begin
                if (rst)
                    q <= '0;
                else
                    q <= hw_ro[DW*i +: DW];
            end
        end else if (TYPE == T_W1C) begin : g_w1c
            // Write-one-to-clear; a hardware set in the same cycle wins.
            always_ff @(posedge clk) begin
                if (rst)
                    q <= '0;
                else
                    q <= (q & ~(wen_hit ? wdata : '0)) | hw_set[DW*i +: DW];
            end
        end else begin : g_rc
            // Clear-on-read; the read returns the pre-clear value and a
            // hardware set in the same cycle survives.
            always_ff @(posedge clk) begin
                if (rst)
                    q <= '0;
                else
                    q <= (q & ~(ren_hit ? {DW{1'b1}} : '0)) | hw_set[DW*i +: DW];
            end
        end
    end

`ifdef REGFILE_IRQ_EN
    logic [DW-1:0] mask_q;
    logic          irq_src;

    // Interrupt mask register, host read/write at address NREG.
    always_ff @(posedge clk) begin
        if (rst)
            mask_q <= '0;
        else if (wen && (addr == AW'(NREG)))
            mask_q <= wdata;
    end

    // Any pending bit in a W1C or RC register is an interrupt source.
    always_comb begin
        irq_src = 1'b0;
        for (int i = 0; i < NREG; i++) begin
            if (REG_TYPE[2*i +: 2] == T_W1C || REG_TYPE[2*i +: 2] == T_RC)
                irq_src = irq_src | (|reg_q[DW*i +: DW]);
        end
    end

    // Registered interrupt, gated by the global enable bit.
    always_ff @(posedge clk) begin
        if (rst)
            irq <= 1'b0;
        else
            irq <= mask_q[0] & irq_src;
    end
`endif

    // Read mux over current register values; zero for unmapped addresses.
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NREG; i++) begin
            if (addr == AW'(i))
                rd_mux = reg_q[DW*i +: DW];
        end
`ifdef REGFILE_IRQ_EN
        if (addr == AW'(NREG))
            rd_mux = mask_q;
`endif
    end

    // Host response: one-cycle read strobe and error strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata  <= '0;
            rvalid <= 1'b0;
            err    <= 1'b0;
        end else begin
            rvalid <= ren;
            rdata  <= (ren && in_range) ? rd_mux : '0;
            err    <= (ren || wen) && !in_range;
        end
    end

endmodule
